// File: rtl/xtea_encoder.sv
// XTEA block encoder, two independent 64-bit lanes sharing one 128-bit key.
// Latency: 2*ROUNDS cycles from the capture edge to done/data_out (64 at default).
// No backpressure: enable is honoured only in IDLE and ignored while busy.
module xtea_encoder #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic [127:0] data_in_i,
    input  logic [127:0] key_in_i,
    output logic [127:0] data_out_o,
    output logic         done_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_Y = 2'd1,
        RUN_Z = 2'd2
    } state_e;

    // The round counter is 8 bits wide, which covers ROUNDS up to 255.
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_e        state_q, state_d;
    logic [31:0]   y0_q, z0_q, y1_q, z1_q;
    logic [31:0]   y0_d, z0_d, y1_d, z1_d;
    logic [127:0]  key_q, key_d;
    logic [31:0]   sum_q, sum_d;
    logic [7:0]    round_q, round_d;
    logic [127:0]  data_out_q, data_out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          last_round;
    logic [31:0]   key_y, key_z;
    logic [31:0]   y0_new, y1_new, z0_new, z1_new;

    // Select key word n from the captured key.
    function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = k[31:0];
            2'd1:    w = k[63:32];
            2'd2:    w = k[95:64];
            default: w = k[127:96];
        endcase
        return w;
    endfunction

    // Feistel mixing term ((v<<4) ^ (v>>5)) + v, logical shifts, mod 2^32.
    function automatic logic [31:0] mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    assign last_round = (round_q == LAST_ROUND);
    assign key_y      = key_word(key_q, sum_q[1:0]);
    // In RUN_Z, sum_q already holds the value advanced during RUN_Y.
    assign key_z      = key_word(key_q, sum_q[12:11]);
    assign y0_new     = y0_q + (mix(z0_q) ^ (sum_q + key_y));
    assign y1_new     = y1_q + (mix(z1_q) ^ (sum_q + key_y));
    assign z0_new     = z0_q + (mix(y0_q) ^ (sum_q + key_z));
    assign z1_new     = z1_q + (mix(y1_q) ^ (sum_q + key_z));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one half-round per clock, alternating y and z.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = RUN_Y;
            RUN_Y:   state_d = RUN_Z;
            RUN_Z:   state_d = last_round ? IDLE : RUN_Y;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture in IDLE, y half-round, then z half-round.
    always_comb begin
        y0_d       = y0_q;
        z0_d       = z0_q;
        y1_d       = y1_q;
        z1_d       = z1_q;
        key_d      = key_q;
        sum_d      = sum_q;
        round_d    = round_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    y0_d    = data_in_i[31:0];
                    z0_d    = data_in_i[63:32];
                    y1_d    = data_in_i[95:64];
                    z1_d    = data_in_i[127:96];
                    key_d   = key_in_i;
                    sum_d   = 32'd0;
                    round_d = 8'd0;
                    busy_d  = 1'b1;
                end
            end
            RUN_Y: begin
                y0_d  = y0_new;
                y1_d  = y1_new;
                sum_d = sum_q + DELTA;
            end
            RUN_Z: begin
                z0_d    = z0_new;
                z1_d    = z1_new;
                round_d = round_q + 8'd1;
                if (last_round) begin
                    data_out_d = {z1_new, y1_q, z0_new, y0_q};
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered-output flops; reset clears everything, aborting any run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y0_q       <= '0;
            z0_q       <= '0;
            y1_q       <= '0;
            z1_q       <= '0;
            key_q      <= '0;
            sum_q      <= '0;
            round_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            y0_q       <= y0_d;
            z0_q       <= z0_d;
            y1_q       <= y1_d;
            z1_q       <= z1_d;
            key_q      <= key_d;
            sum_q      <= sum_d;
            round_q    <= round_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        data_out_o = data_out_q;
        done_o     = done_q;
        busy_o     = busy_q;
    end

endmodule

// File: tb/tb_xtea_encoder.sv
// Scoreboard bench for xtea_encoder: expected ciphertexts queued at drive time,
// popped and compared whenever done pulses.
// Covers reset, zero vector, capture isolation, abort, back-to-back and lane independence.
module tb_xtea_encoder;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam logic [127:0] ZERO_CT = 128'hF7131ED9_DEE9D4D8_F7131ED9_DEE9D4D8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         done;
    logic         busy;

    int n_vec;
    int n_err;
    int n_done;
    logic [127:0] exp_q[$];

    xtea_encoder #(
        .ROUNDS(ROUNDS),
        .DELTA (DELTA)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .data_in_i (data_in),
        .key_in_i  (key_in),
        .data_out_o(data_out),
        .done_o    (done),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference XTEA, written like the textbook C routine.
    function automatic logic [63:0] xtea_ref(input logic [31:0] v0_in, input logic [31:0] v1_in,
                                             input logic [127:0] key);
        logic [31:0] v0, v1, sum;
        logic [31:0] k [4];
        v0 = v0_in;
        v1 = v1_in;
        sum = 32'd0;
        for (int n = 0; n < 4; n++) k[n] = key[32*n +: 32];
        for (int r = 0; r < int'(ROUNDS); r++) begin
            v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum & 32'd3]));
            sum = sum + DELTA;
            v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[(sum >> 11) & 32'd3]));
        end
        return {v1, v0};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] key);
        return {xtea_ref(d[95:64], d[127:96], key), xtea_ref(d[31:0], d[63:32], key)};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) chk("spurious_done", 1'b1, 1'b0);
            else chk("data_out", data_out, exp_q.pop_front());
        end
    end

    // Count edges until done is seen; optionally scramble inputs/enable meanwhile.
    task automatic wait_done(input bit scramble, output int cnt);
        cnt = 0;
        do begin
            if (scramble) begin
                data_in = rnd128();
                key_in  = rnd128();
                enable  = ~enable;
            end
            @(posedge clk); #1;
            cnt++;
        end while (!done && cnt < 300);
        if (scramble) enable = 1'b0;
        if (!done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    // Start one encryption with a one-cycle enable and wait for its result.
    task automatic run_one(input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] exp, input bit scramble, input string tag);
        int cnt;
        int d0;
        d0 = n_done;
        data_in = d;
        key_in  = k;
        enable  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        enable = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(scramble, cnt);
        chk({tag, "_latency"}, cnt, 2 * ROUNDS);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_one_pulse"}, n_done - d0, 1);
    endtask

    initial begin
        int cnt;
        int d0;
        logic [127:0] d, k;
        n_vec = 0;
        n_err = 0;
        n_done = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        data_in = '0;
        key_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // First enable right after release is honoured
        rst_n = 1'b1;
        run_one('0, '0, ZERO_CT, 1'b0, "zero");

        // Inputs and enable scrambled during the run must not matter
        run_one('0, '0, ZERO_CT, 1'b1, "isol");

        // Mid-run reset: outputs clear asynchronously, no done afterwards
        data_in = rnd128();
        key_in  = rnd128();
        enable  = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        data_in = rnd128();
        key_in  = rnd128();
        enable  = 1'($urandom);
        #1;
        chk("arst_data_out", data_out, '0);
        chk("arst_done", done, 1'b0);
        chk("arst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b0;
        d0 = n_done;
        repeat (70) @(posedge clk);
        #1;
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_data_out", data_out, '0);
        chk("abort_busy", busy, 1'b0);
        run_one('0, '0, ZERO_CT, 1'b0, "post_abort");

        // Back-to-back with enable held: result every 2*ROUNDS+1 cycles
        d = rnd128(); k = rnd128();
        data_in = d; key_in = k; enable = 1'b1;
        exp_q.push_back(model(d, k));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                d = rnd128(); k = rnd128();
                data_in = d; key_in = k;
                exp_q.push_back(model(d, k));
            end else begin
                enable = 1'b0;
            end
            wait_done(1'b0, cnt);
            chk("b2b_period", cnt + 1, 2 * ROUNDS + 1);
            if (i < 2) begin
                @(posedge clk); #1;
                chk("b2b_restart_busy", busy, 1'b1);
                chk("b2b_done_fall", done, 1'b0);
            end
        end
        @(posedge clk); #1;
        chk("b2b_idle", busy, 1'b0);

        // Lane independence: lane 0 zero, lane 1 random, zero key
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom, 64'd0};
            exp_q.push_back({xtea_ref(d[95:64], d[127:96], '0), ZERO_CT[63:0]});
            data_in = d; key_in = '0; enable = 1'b1;
            @(posedge clk); #1;
            enable = 1'b0;
            wait_done(1'b0, cnt);
            chk("lane0_fixed", data_out[63:0], ZERO_CT[63:0]);
            @(posedge clk); #1;
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
